// File: rtl/vga_sync.sv
// vga_sync -- pixel-timing generator for the VGA display path.
//
// Divides the board clock down to a pixel-rate strobe, runs the horizontal
// and vertical position counters and produces registered sync / visible
// decodes that always describe the x/y currently on the outputs.
//
// Ports:
//   Clock       in  1        single clock, all state on its rising edge
//   reset       in  1        synchronous, active-high
//   pixel_en    out 1        one-clock strobe in the last clock of each pixel
//   x           out COUNT_W  horizontal position, 0..H_TOTAL-1
//   y           out COUNT_W  vertical position,   0..V_TOTAL-1
//   visible     out 1        (x,y) inside the visible area
//   hsync       out 1        horizontal sync, SYNC_ACTIVE when asserted
//   vsync       out 1        vertical sync,   SYNC_ACTIVE when asserted
//   frame_start out 1        pixel_en of pixel (0,0), once per frame
module vga_sync #(
  parameter int   CLK_DIV     = 2,
  parameter int   H_VISIBLE   = 640,
  parameter int   H_FRONT     = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BACK      = 48,
  parameter int   V_VISIBLE   = 480,
  parameter int   V_FRONT     = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BACK      = 33,
  parameter logic SYNC_ACTIVE = 1'b0,
  parameter int   COUNT_W     = 10
) (
  input  logic               Clock,
  input  logic               reset,
  output logic               pixel_en,
  output logic [COUNT_W-1:0] x,
  output logic [COUNT_W-1:0] y,
  output logic               visible,
  output logic               hsync,
  output logic               vsync,
  output logic               frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  // A one-bit divider is kept even for CLK_DIV=1 so the logic stays uniform;
  // it simply never leaves 0.
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [COUNT_W-1:0] H_LAST   = COUNT_W'(H_TOTAL - 1);
  localparam logic [COUNT_W-1:0] V_LAST   = COUNT_W'(V_TOTAL - 1);
  localparam logic [COUNT_W-1:0] H_VIS    = COUNT_W'(H_VISIBLE);
  localparam logic [COUNT_W-1:0] V_VIS    = COUNT_W'(V_VISIBLE);
  localparam logic [COUNT_W-1:0] HS_BEG   = COUNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [COUNT_W-1:0] HS_END   = COUNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [COUNT_W-1:0] VS_BEG   = COUNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [COUNT_W-1:0] VS_END   = COUNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DIV_W-1:0]   div, div_nxt;
  logic [COUNT_W-1:0] x_nxt, y_nxt;
  logic               vis_nxt, hs_nxt, vs_nxt;

  // Gating with reset matters only for CLK_DIV=1, where div==DIV_LAST always,
  // and for a reset landing on the last clock of a pixel.
  assign pixel_en    = ~reset & (div == DIV_LAST);
  assign frame_start = pixel_en & (x == '0) & (y == '0);

  always_comb begin
    div_nxt = (div == DIV_LAST) ? '0 : div + 1'b1;
  end

  // Next-state position; y only moves on the x wrap, so vsync can only
  // change on the clock that x returns to 0.
  always_comb begin
    x_nxt = x;
    y_nxt = y;
    if (pixel_en) begin
      if (x == H_LAST) begin
        x_nxt = '0;
        y_nxt = (y == V_LAST) ? '0 : y + 1'b1;
      end else begin
        x_nxt = x + 1'b1;
      end
    end
  end

  // Decodes are taken from the next-state position and registered alongside
  // it, so they line up with x/y without an extra pipeline stage.
  always_comb begin
    vis_nxt = (x_nxt < H_VIS) && (y_nxt < V_VIS);
    hs_nxt  = (x_nxt >= HS_BEG) && (x_nxt < HS_END);
    vs_nxt  = (y_nxt >= VS_BEG) && (y_nxt < VS_END);
  end

  always_ff @(posedge Clock) begin
    if (reset) begin
      div     <= '0;
      x       <= '0;
      y       <= '0;
      visible <= 1'b1;
      hsync   <= ~SYNC_ACTIVE;
      vsync   <= ~SYNC_ACTIVE;
    end else begin
      div     <= div_nxt;
      x       <= x_nxt;
      y       <= y_nxt;
      visible <= vis_nxt;
      hsync   <= hs_nxt ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync   <= vs_nxt ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end
  end

endmodule

// File: doc/vga_sync.md
# vga_sync

Pixel-timing generator for the VGA display path. Derives a pixel-rate enable from the board clock, runs horizontal/vertical position counters and produces hsync, vsync, a visible-area flag and the current pixel coordinates. It sits directly upstream of the `digits` renderer, which consumes `x`, `y`, `visible` and `pixel_en` to choose `VGA_R/G/B` and forwards `hsync`/`vsync` to the pins.

## Interface
- `CLK_DIV`, 2, board clocks per pixel (≥1); 50 MHz board → 25 MHz pixel.
- `H_VISIBLE`, 640, visible pixels per line.
- `H_FRONT`, 16, horizontal front porch, pixels.
- `H_SYNC`, 96, hsync pulse width, pixels.
- `H_BACK`, 48, horizontal back porch, pixels.
- `V_VISIBLE`, 480, visible lines per frame.
- `V_FRONT`, 10, vertical front porch, lines.
- `V_SYNC`, 2, vsync pulse width, lines.
- `V_BACK`, 33, vertical back porch, lines.
- `SYNC_ACTIVE`, 0, asserted level of hsync/vsync.
- `COUNT_W`, 10, width of `x`/`y`.

Ports:
- `Clock` in 1: single clock; all state on its rising edge.
- `reset` in 1: synchronous, active-high.
- `pixel_en` out 1: one-clock strobe per pixel period.
- `x` out COUNT_W: horizontal counter, 0..H_TOTAL-1.
- `y` out COUNT_W: vertical counter, 0..V_TOTAL-1.
- `visible` out 1: current (x,y) in the visible area.
- `hsync` out 1: horizontal sync, SYNC_ACTIVE when asserted.
- `vsync` out 1: vertical sync, SYNC_ACTIVE when asserted.
- `frame_start` out 1: one-clock pulse at the first pixel of a frame.

## Operation
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL likewise (525).
- Divider `div` counts 0..CLK_DIV-1, then wraps to 0. `pixel_en` = (div == CLK_DIV-1). With CLK_DIV=1, `pixel_en`=1 every cycle outside reset.
- On a `pixel_en` cycle: x increments. When x=H_TOTAL-1, x wraps to 0 and y increments. When y=V_TOTAL-1 on that same wrap, y wraps to 0.
- x and y hold when `pixel_en`=0.
- Decodes are registered, computed from next-state x/y, so they always describe the x/y currently on the outputs:
  - `visible` = x<H_VISIBLE && y<V_VISIBLE.
  - `hsync` = SYNC_ACTIVE when H_VISIBLE+H_FRONT ≤ x < H_VISIBLE+H_FRONT+H_SYNC (656..751), else ~SYNC_ACTIVE.
  - `vsync` = SYNC_ACTIVE when V_VISIBLE+V_FRONT ≤ y < V_VISIBLE+V_FRONT+V_SYNC (490..491), else ~SYNC_ACTIVE.
  - `frame_start` = `pixel_en` && x==0 && y==0 (combinational).
- There are no out-of-range states: counters never exceed TOTAL-1.

## Timing
- Reset, sampled high at a rising edge, loads: div=0, x=0, y=0, visible=1, hsync=vsync=~SYNC_ACTIVE.
  - While reset is high: `pixel_en`=0 (for CLK_DIV≥2, because div=0; for CLK_DIV=1 it is forced to 0) and `frame_start`=0.
- Reset has priority over counting, so assertion mid-frame returns to (0,0) on the next edge.
- After reset releases, the first `pixel_en` occurs CLK_DIV clocks later. That strobe coincides with `frame_start`=1 at (0,0); the pixel (0,0) is thus consumed first.
- Pixel (x,y) is held for exactly CLK_DIV clocks. `pixel_en` is high in the last of those clocks.
- Line period = H_TOTAL·CLK_DIV clocks (1600). Frame period = H_TOTAL·V_TOTAL·CLK_DIV clocks (840000).
- hsync is asserted for H_SYNC·CLK_DIV clocks (192), starting the clock x becomes 656.
- vsync is asserted for 2 full lines, y=490..491, and changes only at the clock x wraps to 0.
- `frame_start` is high exactly once per frame, for one clock.

## Test plan
- Reset: hold `reset` high for 5 clocks → x=0, y=0, hsync=1, vsync=1, visible=1, `pixel_en`=0, `frame_start`=0. Release → `pixel_en` and `frame_start` both high 2 clocks later.
- Horizontal timing: run one line → `visible` 1 for 640 pixels (1280 clocks); hsync low from x=656 to x=751 (192 clocks); x wraps 799→0 and y steps 0→1 on the same edge.
- Vertical timing: run one frame → vsync low only for y=490..491 (3200 clocks). y wraps 524→0 when x wraps 799→0. The next `frame_start` comes 840000 clocks after the first.
- Mid-frame reset: assert `reset` for 1 clock at x=300, y=200 → next edge x=0, y=0. Frame restarts with `frame_start` 2 clocks after release.
- CLK_DIV=1 with SYNC_ACTIVE=1: `pixel_en` constant 1 after reset. hsync high for x=656..751 (96 clocks). Frame = 420000 clocks.
- Consistency checker, every clock over 2 frames: `visible`/`hsync`/`vsync` match the decode of the current x/y. x,y < TOTAL. `frame_start` implies x=y=0 and `pixel_en`=1.
